// File: rtl/quad_decoder_if.sv
// Bundle of the quadrature decoder's control and pin signals.
// With QUAD_INDEX_EN defined the bundle also carries the quad_idx index pin.
interface quad_decoder_if #(
    parameter int WIDTH = 8
);
    logic             clear;
    logic             quad_a;
    logic             quad_b;
`ifdef QUAD_INDEX_EN
    logic             quad_idx;
`endif
    logic [WIDTH-1:0] count;
    logic             dir_up;
    logic             step;
    logic             err;

`ifdef QUAD_INDEX_EN
    modport master (
        output clear, quad_a, quad_b, quad_idx,
        input  count, dir_up, step, err
    );
    modport slave (
        input  clear, quad_a, quad_b, quad_idx,
        output count, dir_up, step, err
    );
`else
    modport master (
        output clear, quad_a, quad_b,
        input  count, dir_up, step, err
    );
    modport slave (
        input  clear, quad_a, quad_b,
        output count, dir_up, step, err
    );
`endif
endinterface

// File: rtl/quad_decoder.sv
// Quadrature A/B decoder: 2-flop sync, glitch filter, Gray decode, wrapping up/down count.
// Define QUAD_INDEX_EN to add the quad_idx pin, whose filtered rising edge zeroes the count.
//
// state   | meaning
// ST_INIT | waiting for the first filtered A/B level to seed f_prev
// ST_RUN  | decoding every change of the filtered level

module quad_decoder_filt #(
    parameter int N    = 2,
    parameter int FILT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] din,
    output logic [N-1:0] f,
    output logic         settled
);
    localparam logic [3:0] FILT_M1 = 4'(FILT - 1);

    logic [N-1:0] sync1, sync2, s_q;
    logic [3:0]   fcnt, fcnt_base, scnt;
    logic [1:0]   warm;
    logic         stable;

    // A candidate that differs from last cycle's sample starts its run from zero.
    always_comb begin
        fcnt_base = (sync2 == s_q) ? fcnt : 4'd0;
        stable    = warm[1] && (sync2 == f);
        settled   = stable && (scnt == FILT_M1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            s_q   <= '0;
            f     <= '0;
            fcnt  <= '0;
            scnt  <= '0;
            warm  <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            s_q   <= sync2;
            warm  <= {warm[0], 1'b1};
            if (sync2 == f) begin
                fcnt <= '0;
            end else if (fcnt_base == FILT_M1) begin
                f    <= sync2;
                fcnt <= '0;
            end else begin
                fcnt <= fcnt_base + 4'd1;
            end
            if (!stable) begin
                scnt <= '0;
            end else if (scnt != FILT_M1) begin
                scnt <= scnt + 4'd1;
            end
        end
    end
endmodule

module quad_decoder #(
    parameter int WIDTH = 8,
    parameter int FILT  = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    quad_decoder_if.slave  bus
);
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t           state, state_nxt;
    logic [1:0]       f, f_prev;
    logic             ab_settled;
    logic             load_prev, do_up, do_dn, do_err, idx_rise;
    logic [WIDTH-1:0] count_q;
    logic             dir_q, step_q, err_q;

    quad_decoder_filt #(.N(2), .FILT(FILT)) u_ab_filt (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     ({bus.quad_a, bus.quad_b}),
        .f       (f),
        .settled (ab_settled)
    );

`ifdef QUAD_INDEX_EN
    logic idx_f, idx_prev, idx_settled, idx_armed;

    quad_decoder_filt #(.N(1), .FILT(FILT)) u_idx_filt (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (bus.quad_idx),
        .f       (idx_f),
        .settled (idx_settled)
    );

    // An index level already high at reset release is not treated as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_prev  <= 1'b0;
            idx_armed <= 1'b0;
        end else begin
            idx_prev  <= idx_f;
            idx_armed <= idx_armed | idx_settled;
        end
    end

    assign idx_rise = idx_armed & idx_f & ~idx_prev;
`else
    assign idx_rise = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_prev = 1'b0;
        do_up     = 1'b0;
        do_dn     = 1'b0;
        do_err    = 1'b0;
        case (state)
            ST_INIT: begin
                if ((f != f_prev) || ab_settled) begin
                    load_prev = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (f != f_prev) begin
                    load_prev = 1'b1;
                    case ({f_prev, f})
                        4'b0001, 4'b0111, 4'b1110, 4'b1000: do_up  = 1'b1;
                        4'b0100, 4'b1101, 4'b1011, 4'b0010: do_dn  = 1'b1;
                        default:                            do_err = 1'b1;
                    endcase
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_prev  <= 2'b00;
            count_q <= '0;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (load_prev) begin
                f_prev <= f;
            end
            if (bus.clear) begin
                count_q <= '0;
                err_q   <= 1'b0;
                step_q  <= 1'b0;
            end else begin
                step_q <= do_up | do_dn;
                if (do_up | do_dn) begin
                    dir_q <= do_up;
                end
                if (idx_rise) begin
                    count_q <= '0;
                end else if (do_up) begin
                    count_q <= count_q + WIDTH'(1);
                end else if (do_dn) begin
                    count_q <= count_q - WIDTH'(1);
                end
                if (do_err) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign bus.count  = count_q;
    assign bus.dir_up = dir_q;
    assign bus.step   = step_q;
    assign bus.err    = err_q;
endmodule

// File: doc/quad_decoder.md
Name: quad_decoder

Overview:
- Receiver end of a quadrature (A/B) encoder interface. Recovers step and direction from two asynchronous phase inputs and keeps a signed-agnostic up/down position count.
- The counterpart to the up/down counter family: the counter produces count plus direction, and this block reconstructs direction and count from the physical A/B waveform.
- Sits between encoder pins and the control logic, in a single clock domain.

Parameters:
- WIDTH, 8, width of the position count; the count wraps modulo 2^WIDTH.
- FILT, 2, number of consecutive stable synchronized samples needed to accept a new A/B level (legal range 1..15).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous clear of count and err.
- quad_a  input  1  encoder phase A; asynchronous to clk.
- quad_b  input  1  encoder phase B; asynchronous to clk.
- count  output  WIDTH  position count.
- dir_up  output  1  direction of the last accepted step: 1 = up, 0 = down.
- step  output  1  one-cycle pulse per accepted step.
- err  output  1  sticky flag for an illegal transition (both phases changed).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - count=0, dir_up=0, step=0, err=0.
  - Synchronizer flops, filter counter and filtered state cleared.
  - init flag cleared.
- Synchronizer: quad_a and quad_b each pass through 2 flops. The result is s = {a_s, b_s}.
- Glitch filter:
  - f holds the accepted 2-bit level; fcnt counts consecutive cycles with s != f.
  - When s == f, fcnt resets to 0.
  - When s != f for FILT consecutive cycles, f <= s and fcnt <= 0.
  - If s changes value mid-count (for example 01 then 11), fcnt restarts.
  - A pulse shorter than FILT cycles never reaches f.
- First sample after reset:
  - While init=0, the first filtered update simply loads f_prev. No step, no err. init is then set.
  - Before that first update, f_prev is loaded with s once s has been stable FILT cycles.
  - This prevents a false err when the pins are not at 00 on reset release.
- Decode: {a,b} Gray sequence.
  - Up: 00 -> 01 -> 11 -> 10 -> 00.
  - Down is the reverse order.
  - Evaluated in the cycle after f changes, comparing f with f_prev:
    - Up transition: count <= count+1, dir_up <= 1, step <= 1.
    - Down transition: count <= count-1, dir_up <= 0, step <= 1.
    - No change: step <= 0; count and dir_up hold.
    - Both bits changed (00<->11, 01<->10): err <= 1, step <= 0; count and dir_up unchanged. f_prev still tracks f, so decoding resynchronizes.
- Latency: a pin change captured by sync flop 1 at edge N produces count/step/dir_up at edge N+2+FILT.
  - Example: FILT=2 gives edge N+4.
- Steps can be accepted every FILT+1 cycles at most. Faster input is a system-level violation, not detected.
- Wrap-around:
  - All ones + up gives 0.
  - 0 + down gives all ones.
  - err is not set on wrap.
- clear=1:
  - count <= 0, err <= 0, step <= 0 in that cycle. dir_up holds.
  - Filter, f_prev and init are not disturbed.
  - If a valid step is decoded in the same cycle, clear wins and that step is dropped.
- err stays set until clear or reset.
- Reset asserted mid-operation: all outputs go to reset values immediately. Decoding restarts with the init sequence.

Optional Feature:
- Macro: QUAD_INDEX_EN.
- Defined:
  - Adds input quad_idx (1 bit, asynchronous), with its own 2-flop synchronizer and the same FILT filter.
  - On the filtered rising edge of the index, count <= 0 in the same cycle the decoder would update.
  - If a step is decoded in that same cycle, the index wins and count = 0; step and dir_up still update for that step.
  - clear still has priority over everything.
- Undefined: no quad_idx port; count changes only on steps, clear and reset.

Test Plan:
- Reset/init: hold rst_n=0 with pins at 11, then release. After a 30-cycle wait: count=0, err=0, step never pulsed.
- Up sequence: WIDTH=3, FILT=2, 10 up transitions spaced 8 clks.
  - Response: 10 single-cycle step pulses, dir_up=1, count ends at 2 (wraps at 7->0).
  - Check that each count update lands exactly 4 edges after capture.
- Down then reverse: from count=0, 3 down transitions, then 2 up transitions.
  - Down phase: count 7, 6, 5 with dir_up=0.
  - Up phase: count 6, 7 with dir_up=1.
- Glitch: with FILT=3, pulse quad_a for 2 clks, then for 3 clks.
  - 2-clk pulse: no step, count unchanged.
  - 3-clk pulse: one step, then one reverse step.
- Illegal transition: force 00 -> 11.
  - Response: err=1, count unchanged, no step.
  - Following legal 11 -> 10 gives count+1.
  - clear pulse gives err=0, count=0.
- Clear collision: assert clear in the exact cycle a step would land. Response: count=0 and step=0.
- With QUAD_INDEX_EN: index pulse at count=5 gives count=0 after the latency.
